// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding, frame length,
// break-code constant and an odd-parity helper for downstream users.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Start + 8 data + parity + stop.
  localparam int unsigned PS2_FRAME_BITS = 11;

  // Break (key release) prefix; the receiver itself treats it as ordinary data.
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// PS/2 receiver bus: device-side lines in, decoded byte and strobes out.
// master = PS/2 device / host model side, slave = the receiver.
interface ps2_rx_frame_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keyboard_data;
  logic       data_received_en;
  logic       frame_error;

  modport master (
    output PS2_CLK, PS2_DAT,
    input  keyboard_data, data_received_en, frame_error
  );

  modport slave (
    input  PS2_CLK, PS2_DAT,
    output keyboard_data, data_received_en, frame_error
  );
endinterface

// File: rtl/ps2_sync_filter.sv
// PS2_CLK conditioning: 2-flop synchronizer, FILTER_LEN-sample glitch
// filter and a one-cycle pulse on each filtered 1->0 transition.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic async_in,
  output logic fall_pulse
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             sync_1, sync_2;
  logic             filt, filt_d;
  logic [CNT_W-1:0] filt_cnt;

  // Synchronize the asynchronous line; idle level is high.
  // NOTE: reset here is synchronous (sampled on CLOCK_50), so it sits inside the clocked branch, not in the sensitivity list.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      // NOTE: registers use non-blocking '<=' so every flop samples the pre-edge values; blocking here would collapse the 2-flop chain.
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= async_in;
      sync_2 <= sync_1;
    end
  end

  // Move the filtered level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d <= filt;
      if (sync_2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == CNT_W'(FILTER_LEN - 1)) begin
        filt     <= sync_2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + CNT_W'(1);
      end
    end
  end

  assign fall_pulse = filt_d & ~filt;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: samples PS2_DAT on filtered PS2_CLK falling edges,
// assembles start/8 data/parity/stop frames and emits a byte strobe or a
// frame_error strobe. Partial frames are aborted after TIMEOUT_CYCLES.
// Optional build macro: PS2_PARITY_CHECK_EN (reject frames with even parity).
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  ps2_rx_frame_if.slave  bus
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic            clk_fall;
  logic            dat_s1, dat_s2;
  ps2_state_e      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic [TO_W-1:0] idle_cnt;
  logic [7:0]      kbd_q;
  logic            rx_en_q;
  logic            err_q;
  logic            parity_ok;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .async_in   (bus.PS2_CLK),
    .fall_pulse (clk_fall)
  );

  // Data line only needs metastability protection; it is sampled on clk_fall.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      dat_s1 <= bus.PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;

  // Hold the received parity bit until the stop bit decides the frame.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn)
      parity_bit <= 1'b0;
    else if (clk_fall && state == PARITY)
      parity_bit <= dat_s2;
  end

  assign parity_ok = ps2_odd_parity_ok(shift_reg, parity_bit);
`else
  // Parity bit is clocked through the PARITY state but not judged.
  assign parity_ok = 1'b1;
`endif

  // Frame FSM with idle timeout; strobes are registered one-cycle pulses.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      idle_cnt  <= '0;
      kbd_q     <= 8'h00;
      rx_en_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_en_q <= 1'b0;
      err_q   <= 1'b0;
      if (clk_fall) begin
        // An edge always restarts the timeout, even on the cycle it would expire.
        idle_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {dat_s2, shift_reg[7:1]};
            if (bit_cnt == 3'd7)
              state <= PARITY;
            else
              bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: begin
            state <= STOP;
          end
          STOP: begin
            if (dat_s2 && parity_ok) begin
              kbd_q   <= shift_reg;
              rx_en_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        err_q    <= 1'b1;
        state    <= IDLE;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
    end
  end

  assign bus.keyboard_data    = kbd_q;
  assign bus.data_received_en = rx_en_q;
  assign bus.frame_error      = err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Testbench for ps2_rx_frame: drives PS/2 frames with randomized timing and
// compares decoded bytes / error strobes against a frame-level model.
module tb_ps2_rx_frame;
  import ps2_pkg::*;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 50000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cyc      = 0;
  longint      last_fall_cyc = 0;
  logic [7:0]  rx_q[$];
  longint      err_q[$];
  int          overlap_cnt = 0;
  int          wide_cnt    = 0;
  logic        prev_en  = 1'b0;
  logic        prev_err = 1'b0;
  logic [7:0]  exp_kbd  = 8'h00;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Record every strobe and flag overlaps / strobes longer than one cycle.
  always @(negedge CLOCK_50) begin
    if (bus.data_received_en === 1'b1) rx_q.push_back(bus.keyboard_data);
    if (bus.frame_error === 1'b1) err_q.push_back(cyc);
    if (bus.data_received_en === 1'b1 && bus.frame_error === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if ((prev_en && bus.data_received_en === 1'b1) || (prev_err && bus.frame_error === 1'b1))
      wide_cnt <= wide_cnt + 1;
    prev_en  <= (bus.data_received_en === 1'b1);
    prev_err <= (bus.frame_error === 1'b1);
  end

  // Frame-level model: accept iff stop bit is 1 and, when enabled, ones(data,parity) is odd.
  function automatic bit model_accept(input logic [7:0] d, input logic p, input logic s);
    int ones;
    ones = $countones({d, p});
    return (s == 1'b1) && (!PARITY_EN || (ones % 2 == 1));
  endfunction

  function automatic logic good_parity(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic ps2_bit(input logic b, input int hi, input int lo);
    bus.PS2_DAT = b;
    wait_cycles(hi);
    bus.PS2_CLK = 1'b0;
    last_fall_cyc = cyc;
    wait_cycles(lo);
    bus.PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int hi, input int lo);
    ps2_bit(1'b0, hi, lo);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], hi, lo);
    ps2_bit(p, hi, lo);
    ps2_bit(s, hi, lo);
    bus.PS2_DAT = 1'b1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    err_q.delete();
  endtask

  task automatic test_reset();
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    resetn = 1'b0;
    wait_cycles(5);
    n_checks++;
    if (bus.keyboard_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_kbd: got %0h expected 00", bus.keyboard_data);
    end
    n_checks++;
    if (bus.data_received_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_en: got %0b expected 0", bus.data_received_en);
    end
    n_checks++;
    if (bus.frame_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %0b expected 0", bus.frame_error);
    end
    resetn = 1'b1;
    clear_mon();
    wait_cycles(20);
    n_checks++;
    if (rx_q.size() + err_q.size() != 0) begin
      n_fail++; $display("FAIL reset_quiet: got %0d strobes expected 0", rx_q.size() + err_q.size());
    end
    exp_kbd = 8'h00;
  endtask

  task automatic test_single_frame();
    clear_mon();
    send_frame(8'h1C, 1'b0, 1'b1, 20, 20);
    wait_cycles(40);
    exp_kbd = 8'h1C;
    n_checks++;
    if (rx_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d strobes expected 1", rx_q.size());
    end
    if (rx_q.size() > 0) begin
      n_checks++;
      if (rx_q[0] !== 8'h1C) begin
        n_fail++; $display("FAIL single_value: got %0h expected 1c", rx_q[0]);
      end
    end
    n_checks++;
    if (err_q.size() != 0) begin
      n_fail++; $display("FAIL single_err: got %0d errors expected 0", err_q.size());
    end
    n_checks++;
    if (bus.keyboard_data !== exp_kbd) begin
      n_fail++; $display("FAIL single_hold: got %0h expected %0h", bus.keyboard_data, exp_kbd);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(PS2_BREAK_CODE, good_parity(PS2_BREAK_CODE), 1'b1, 15, 15);
    send_frame(8'h1C, good_parity(8'h1C), 1'b1, 15, 15);
    wait_cycles(40);
    exp_kbd = 8'h1C;
    n_checks++;
    if (rx_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d strobes expected 2", rx_q.size());
    end else begin
      n_checks++;
      if (rx_q[0] !== 8'hF0 || rx_q[1] !== 8'h1C) begin
        n_fail++; $display("FAIL b2b_values: got %0h,%0h expected f0,1c", rx_q[0], rx_q[1]);
      end
    end
    n_checks++;
    if (err_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_err: got %0d errors expected 0", err_q.size());
    end
  endtask

  task automatic test_bad_frames();
    bit acc;
    // Wrong parity on 0x1C: outcome depends on whether parity is judged.
    clear_mon();
    acc = model_accept(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1, 20, 20);
    wait_cycles(40);
    if (acc) exp_kbd = 8'h1C;
    n_checks++;
    if (rx_q.size() != (acc ? 1 : 0)) begin
      n_fail++; $display("FAIL parity_strobe: got %0d strobes expected %0d", rx_q.size(), acc ? 1 : 0);
    end
    n_checks++;
    if (err_q.size() != (acc ? 0 : 1)) begin
      n_fail++; $display("FAIL parity_err: got %0d errors expected %0d", err_q.size(), acc ? 0 : 1);
    end
    n_checks++;
    if (bus.keyboard_data !== exp_kbd) begin
      n_fail++; $display("FAIL parity_hold: got %0h expected %0h", bus.keyboard_data, exp_kbd);
    end
    // Bad stop bit: always rejected, byte held.
    clear_mon();
    send_frame(8'h33, good_parity(8'h33), 1'b0, 20, 20);
    wait_cycles(40);
    n_checks++;
    if (rx_q.size() != 0 || err_q.size() != 1) begin
      n_fail++; $display("FAIL stop_bad: got %0d strobes %0d errors expected 0 and 1", rx_q.size(), err_q.size());
    end
    n_checks++;
    if (bus.keyboard_data !== exp_kbd) begin
      n_fail++; $display("FAIL stop_hold: got %0h expected %0h", bus.keyboard_data, exp_kbd);
    end
  endtask

  task automatic test_timeout();
    longint lat;
    clear_mon();
    ps2_bit(1'b0, 20, 20);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)), 20, 20);
    bus.PS2_DAT = 1'b1;
    wait_cycles(60000);
    n_checks++;
    if (err_q.size() != 1 || rx_q.size() != 0) begin
      n_fail++; $display("FAIL timeout_count: got %0d errors %0d strobes expected 1 and 0", err_q.size(), rx_q.size());
    end
    if (err_q.size() > 0) begin
      lat = err_q[0] - last_fall_cyc;
      n_checks++;
      if (lat < TIMEOUT_CYCLES || lat > TIMEOUT_CYCLES + 40) begin
        n_fail++; $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", lat, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 40);
      end
    end
    clear_mon();
    send_frame(8'h29, good_parity(8'h29), 1'b1, 20, 20);
    wait_cycles(40);
    exp_kbd = 8'h29;
    n_checks++;
    if (rx_q.size() != 1 || err_q.size() != 0) begin
      n_fail++; $display("FAIL after_timeout_count: got %0d strobes %0d errors expected 1 and 0", rx_q.size(), err_q.size());
    end
    n_checks++;
    if (bus.keyboard_data !== 8'h29) begin
      n_fail++; $display("FAIL after_timeout_value: got %0h expected 29", bus.keyboard_data);
    end
  endtask

  task automatic test_glitch();
    // A short low glitch with data low would look like a start bit if accepted.
    clear_mon();
    bus.PS2_DAT = 1'b0;
    wait_cycles(20);
    bus.PS2_CLK = 1'b0;
    wait_cycles(3);
    bus.PS2_CLK = 1'b1;
    wait_cycles(30);
    bus.PS2_DAT = 1'b1;
    wait_cycles(30);
    send_frame(8'hA5, good_parity(8'hA5), 1'b1, 20, 20);
    wait_cycles(40);
    n_checks++;
    if (rx_q.size() != 1 || err_q.size() != 0) begin
      n_fail++; $display("FAIL glitch_count: got %0d strobes %0d errors expected 1 and 0", rx_q.size(), err_q.size());
    end else begin
      n_checks++;
      if (rx_q[0] !== 8'hA5) begin
        n_fail++; $display("FAIL glitch_value: got %0h expected a5", rx_q[0]);
      end
    end
    // Ten-cycle low pulses are long enough to count as edges.
    clear_mon();
    send_frame(8'h3C, good_parity(8'h3C), 1'b1, 20, 10);
    wait_cycles(40);
    exp_kbd = 8'h3C;
    n_checks++;
    if (rx_q.size() != 1 || err_q.size() != 0) begin
      n_fail++; $display("FAIL short_low_count: got %0d strobes %0d errors expected 1 and 0", rx_q.size(), err_q.size());
    end
    n_checks++;
    if (bus.keyboard_data !== 8'h3C) begin
      n_fail++; $display("FAIL short_low_value: got %0h expected 3c", bus.keyboard_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    ps2_bit(1'b0, 20, 20);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 20, 20);
    wait_cycles(5);
    resetn = 1'b0;
    wait_cycles(3);
    exp_kbd = 8'h00;
    n_checks++;
    if (bus.keyboard_data !== 8'h00 || bus.data_received_en !== 1'b0 || bus.frame_error !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got kbd %0h en %0b err %0b expected 00 0 0",
                         bus.keyboard_data, bus.data_received_en, bus.frame_error);
    end
    resetn = 1'b1;
    bus.PS2_DAT = 1'b1;
    wait_cycles(20);
    n_checks++;
    if (rx_q.size() != 0 || err_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_quiet: got %0d strobes %0d errors expected 0 and 0", rx_q.size(), err_q.size());
    end
    clear_mon();
    send_frame(8'h5A, good_parity(8'h5A), 1'b1, 20, 20);
    wait_cycles(40);
    exp_kbd = 8'h5A;
    n_checks++;
    if (rx_q.size() != 1 || err_q.size() != 0 || bus.keyboard_data !== 8'h5A) begin
      n_fail++; $display("FAIL midreset_next: got %0d strobes %0d errors kbd %0h expected 1 0 5a",
                         rx_q.size(), err_q.size(), bus.keyboard_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_err;
    logic [7:0] d;
    logic       p, s;
    int         mode;
    exp_err = 0;
    clear_mon();
    for (int f = 0; f < 16; f++) begin
      d    = 8'($urandom);
      mode = $urandom_range(0, 9);
      if (mode == 9) d = PS2_BREAK_CODE;
      p = good_parity(d);
      s = 1'b1;
      if (mode == 7) p = ~p;
      if (mode == 8) s = 1'b0;
      if (model_accept(d, p, s)) begin
        exp_q.push_back(d);
        exp_kbd = d;
      end else begin
        exp_err++;
      end
      send_frame(d, p, s, $urandom_range(12, 30), $urandom_range(12, 30));
      wait_cycles($urandom_range(0, 10));
    end
    wait_cycles(40);
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d strobes expected %0d", rx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (rx_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_value[%0d]: got %0h expected %0h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (err_q.size() != exp_err) begin
      n_fail++; $display("FAIL rand_errors: got %0d expected %0d", err_q.size(), exp_err);
    end
    n_checks++;
    if (bus.keyboard_data !== exp_kbd) begin
      n_fail++; $display("FAIL rand_hold: got %0h expected %0h", bus.keyboard_data, exp_kbd);
    end
  endtask

  task automatic test_strobe_rules();
    n_checks++;
    if (overlap_cnt != 0) begin
      n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap_cnt);
    end
    n_checks++;
    if (wide_cnt != 0) begin
      n_fail++; $display("FAIL strobe_width: got %0d multi-cycle strobes expected 0", wide_cnt);
    end
  endtask

  initial begin
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_frames();
    test_glitch();
    test_reset_mid_frame();
    test_random();
    test_timeout();
    test_strobe_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
